// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register:
// mode encodings and the shift/rotate classifier.
package univ_shift_reg_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_CLR  = 3'b110;

    // Shifts and rotates share one count toward the done pulse
    function automatic logic is_shift(input mode_t mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

    function automatic logic is_clear(input mode_t mode);
        return (mode == MODE_LOAD) || (mode == MODE_CLR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle of the universal shift register.
// The master drives operations, the slave returns register state.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    import univ_shift_reg_pkg::*;

    localparam int CW = (WIDTH == 2) ? 1 : $clog2(WIDTH);

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, qbar, sout_l, sout_r, cnt, done
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, qbar, sout_l, sout_r, cnt, done
    );

endinterface

// File: rtl/sr_shift_counter.sv
// Wrap counter of shift/rotate operations; pulses done for one
// cycle on the edge that wraps WIDTH-1 back to zero.
module sr_shift_counter #(
    parameter  int WIDTH = 8,
    localparam int CW    = (WIDTH == 2) ? 1 : $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    // Clear wins over a simultaneous wrap, so no pulse is emitted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (inc) begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_done <= w_wrap;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, shift, rotate and clear,
// with true/complement outputs and a WIDTH-shift done pulse.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic           clk,
    input logic           rst,
    univ_shift_reg_if.slave bus
);
    import univ_shift_reg_pkg::*;

    localparam int CW = (WIDTH == 2) ? 1 : $clog2(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    w_cnt;
    logic             w_done;
    logic             w_inc;
    logic             w_clr;

    assign w_inc = is_shift(bus.mode);
    assign w_clr = is_clear(bus.mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_LOAD: r_q <= bus.d;
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], bus.sin_r};
                MODE_SHR:  r_q <= {bus.sin_l, r_q[WIDTH-1:1]};
                MODE_ROL:  r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_ROR:  r_q <= {r_q[0], r_q[WIDTH-1:1]};
                MODE_CLR:  r_q <= '0;
                default:   r_q <= r_q;
            endcase
        end
    end

    sr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .inc  (w_inc),
        .clr  (w_clr),
        .cnt  (w_cnt),
        .done (w_done)
    );

    assign bus.q      = r_q;
    assign bus.qbar   = ~r_q;
    assign bus.sout_l = r_q[WIDTH-1];
    assign bus.sout_r = r_q[0];
    assign bus.cnt    = w_cnt;
    assign bus.done   = w_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg, WIDTH=8,
// RESET_VAL=8'h00, with hand-computed expected values.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    univ_shift_reg_if #(.WIDTH(8)) bus();

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input mode_t m,
                         input logic [7:0] d,
                         input logic sl, input logic sr);
        bus.en    = en;
        bus.mode  = m;
        bus.d     = d;
        bus.sin_l = sl;
        bus.sin_r = sr;
    endtask

    task automatic test_reset();
        n_total++;
        if (bus.q !== 8'h00 || bus.cnt !== 3'd0 || bus.done !== 1'b0)
            $display("FAIL init_reset q=%h cnt=%0d done=%b want 00/0/0",
                     bus.q, bus.cnt, bus.done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, MODE_LOAD, 8'hB4, 1'b0, 1'b0);
        tick();
        drive(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        n_total++;
        if (bus.q !== 8'hA5 || bus.cnt !== 3'd3)
            $display("FAIL pre_reset q=%h cnt=%0d want A5/3",
                     bus.q, bus.cnt);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.q !== 8'h00 || bus.qbar !== 8'hFF ||
            bus.cnt !== 3'd0 || bus.done !== 1'b0)
            $display("FAIL async_reset q=%h qbar=%h cnt=%0d done=%b want 00/FF/0/0",
                     bus.q, bus.qbar, bus.cnt, bus.done);
        else n_pass++;
        drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        drive(1'b1, MODE_LOAD, 8'h96, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.q !== 8'h96 || bus.qbar !== 8'h69 ||
            bus.sout_l !== 1'b1 || bus.sout_r !== 1'b0 ||
            bus.cnt !== 3'd0)
            $display("FAIL load q=%h qbar=%h sl=%b sr=%b cnt=%0d want 96/69/1/0/0",
                     bus.q, bus.qbar, bus.sout_l, bus.sout_r, bus.cnt);
        else n_pass++;
    endtask

    task automatic test_shift();
        drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
        tick();
        n_total++;
        if (bus.q !== 8'h2D || bus.cnt !== 3'd1)
            $display("FAIL shl q=%h cnt=%0d want 2D/1", bus.q, bus.cnt);
        else n_pass++;
        drive(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
        tick();
        n_total++;
        if (bus.q !== 8'h16 || bus.cnt !== 3'd2)
            $display("FAIL shr q=%h cnt=%0d want 16/2", bus.q, bus.cnt);
        else n_pass++;
        drive(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
        tick();
        n_total++;
        if (bus.q !== 8'h8B || bus.cnt !== 3'd3)
            $display("FAIL shr_sin1 q=%h cnt=%0d want 8B/3", bus.q, bus.cnt);
        else n_pass++;
    endtask

    task automatic test_rotate();
        drive(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        tick();
        drive(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.q !== 8'h03 || bus.cnt !== 3'd1)
            $display("FAIL rol q=%h cnt=%0d want 03/1", bus.q, bus.cnt);
        else n_pass++;
        drive(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        tick();
        drive(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.q !== 8'hC0 || bus.cnt !== 3'd1)
            $display("FAIL ror q=%h cnt=%0d want C0/1", bus.q, bus.cnt);
        else n_pass++;
    endtask

    task automatic test_serializer();
        logic [7:0] exp_sl;
        exp_sl = 8'b1100_0011;
        drive(1'b1, MODE_LOAD, 8'hC3, 1'b0, 1'b0);
        tick();
        drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (bus.sout_l !== exp_sl[7-i])
                $display("FAIL ser_sout_l[%0d] got=%b want=%b",
                         i, bus.sout_l, exp_sl[7-i]);
            else n_pass++;
            tick();
            if (i < 7) begin
                n_total++;
                if (bus.done !== 1'b0 || bus.cnt !== 3'(i + 1))
                    $display("FAIL ser_mid[%0d] done=%b cnt=%0d want 0/%0d",
                             i, bus.done, bus.cnt, i + 1);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.done !== 1'b1 || bus.cnt !== 3'd0 || bus.q !== 8'h00)
            $display("FAIL ser_end done=%b cnt=%0d q=%h want 1/0/00",
                     bus.done, bus.cnt, bus.q);
        else n_pass++;
        drive(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.done !== 1'b0 || bus.cnt !== 3'd0)
            $display("FAIL ser_done_fall done=%b cnt=%0d want 0/0",
                     bus.done, bus.cnt);
        else n_pass++;
    endtask

    task automatic test_en_priority();
        drive(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
        repeat (7) tick();
        n_total++;
        if (bus.q !== 8'h80 || bus.cnt !== 3'd7)
            $display("FAIL pre_hold q=%h cnt=%0d want 80/7", bus.q, bus.cnt);
        else n_pass++;
        drive(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (bus.q !== 8'h80 || bus.cnt !== 3'd7 || bus.done !== 1'b0)
                $display("FAIL en_low[%0d] q=%h cnt=%0d done=%b want 80/7/0",
                         i, bus.q, bus.cnt, bus.done);
            else n_pass++;
        end
        drive(1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0);
        tick();
        n_total++;
        if (bus.q !== 8'h5A || bus.cnt !== 3'd0 || bus.done !== 1'b0)
            $display("FAIL load_prio q=%h cnt=%0d done=%b want 5A/0/0",
                     bus.q, bus.cnt, bus.done);
        else n_pass++;
    endtask

    task automatic test_clr_reserved();
        drive(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b1, 3'b111, 8'hFF, 1'b1, 1'b1);
        tick();
        n_total++;
        if (bus.q !== 8'h96 || bus.cnt !== 3'd2 || bus.done !== 1'b0)
            $display("FAIL reserved q=%h cnt=%0d done=%b want 96/2/0",
                     bus.q, bus.cnt, bus.done);
        else n_pass++;
        drive(1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1);
        tick();
        n_total++;
        if (bus.q !== 8'h00 || bus.qbar !== 8'hFF || bus.cnt !== 3'd0)
            $display("FAIL clr q=%h qbar=%h cnt=%0d want 00/FF/0",
                     bus.q, bus.qbar, bus.cnt);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        #1;
        test_reset();
        test_load();
        test_shift();
        test_rotate();
        test_serializer();
        test_en_priority();
        test_clr_reserved();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
